hazard_ctrl: RTL and testbench

- Central stall/flush controller for the RV32I 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC hold.
- Resolves load-use hazards, EX-stage redirects, instruction-fetch wait and data-bus wait states for the custom peripherals.
- Includes a bus watchdog that aborts a hung data access.

---
 rtl/rv32_pkg.sv | 13 +
 rtl/hazard_watchdog.sv | 73 +++++++
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I pipeline control blocks.
// Holds the hazard FSM state encoding and the register-index width.
package rv32_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ABORT    = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_watchdog.sv
// Data-bus wait sequencer: tracks MEM wait cycles and aborts a hung access.
//   state    | meaning
//   RUN      | no data-bus wait outstanding
//   MEM_WAIT | access pending, counter holds wait cycles so far
//   ABORT    | one-cycle abort of the hung access, bus_err high
module hazard_watchdog
    import rv32_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      dmem_req_i,
    input  logic      dmem_ready_i,
    output hz_state_e state_o,
    output logic      bus_err_o
);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
        case (state_q)
            RUN: begin
                if (dmem_req_i && !dmem_ready_i) begin
                    state_d = MEM_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                // Completion (or a withdrawn request) beats the timeout in the same cycle.
                if (!dmem_req_i || dmem_ready_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = ABORT;
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ABORT: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign state_o   = state_q;
    assign bus_err_o = bus_err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline with bus watchdog.
// Optional performance counters are built when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
    import rv32_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_redirect,
    input  logic                 imem_ready,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic                 pc_stall,
    output logic                 ifid_stall,
    output logic                 ifid_flush,
    output logic                 idex_stall,
    output logic                 idex_flush,
    output logic                 exmem_stall,
    output logic                 exmem_flush,
    output logic                 memwb_flush,
    output logic                 bus_err,
    output logic [31:0]          perf_stall_cyc,
    output logic [31:0]          perf_flush_cnt
);

    hz_state_e state;
    logic      memwait;
    logic      loaduse;

    hazard_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk          (clk),
        .reset        (reset),
        .dmem_req_i   (dmem_req),
        .dmem_ready_i (dmem_ready),
        .state_o      (state),
        .bus_err_o    (bus_err)
    );

    assign memwait = dmem_req && !dmem_ready && (state == RUN || state == MEM_WAIT);
    assign loaduse = ex_mem_read && (ex_rd != '0) &&
                     ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (reset) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (memwait) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            // The aborted access is killed in MEM while the front end keeps resolving its own hazards.
            if (state == ABORT) begin
                exmem_flush = 1'b1;
                memwb_flush = 1'b1;
            end
            if (ex_redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (loaduse) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end else if (!imem_ready) begin
                pc_stall   = 1'b1;
                ifid_flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (pc_stall) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (ex_redirect && !memwait) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cyc = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl, built with TIMEOUT=4.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic        ex_mem_read = 1'b0, ex_redirect = 1'b0;
    logic        imem_ready = 1'b1, dmem_req = 1'b0, dmem_ready = 1'b0;
    logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic        exmem_stall, exmem_flush, memwb_flush, bus_err;
    logic [31:0] perf_stall_cyc, perf_flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_redirect    (ex_redirect),
        .imem_ready     (imem_ready),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .pc_stall       (pc_stall),
        .ifid_stall     (ifid_stall),
        .ifid_flush     (ifid_flush),
        .idex_stall     (idex_stall),
        .idex_flush     (idex_flush),
        .exmem_stall    (exmem_stall),
        .exmem_flush    (exmem_flush),
        .memwb_flush    (memwb_flush),
        .bus_err        (bus_err),
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt)
    );

    // Expected bit order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
    //                      exmem_stall, exmem_flush, memwb_flush, bus_err}
    localparam logic [8:0] E_NONE  = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] E_RST   = 9'b0_0_1_0_1_0_1_1_0;
    localparam logic [8:0] E_MEMW  = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] E_LU    = 9'b1_1_0_0_1_0_0_0_0;
    localparam logic [8:0] E_REDIR = 9'b0_0_1_0_1_0_0_0_0;
    localparam logic [8:0] E_FW    = 9'b1_0_1_0_0_0_0_0_0;
    localparam logic [8:0] E_ABORT = 9'b0_0_0_0_0_0_1_1_1;
    localparam logic [8:0] E_AB_RD = 9'b0_0_1_0_1_0_1_1_1;

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2;
        logic       use1, use2;
        logic [4:0] exrd;
        logic       exmr, redir, imrdy, dreq, drdy;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    function automatic vec_t mk(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic use1, input logic use2, input logic [4:0] exrd,
                                input logic exmr, input logic redir, input logic imrdy,
                                input logic dreq, input logic drdy, input logic [8:0] exp);
        vec_t v;
        v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
        v.exrd = exrd; v.exmr = exmr; v.redir = redir; v.imrdy = imrdy;
        v.dreq = dreq; v.drdy = drdy; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t w(input logic dreq, input logic drdy, input logic redir,
                               input logic [8:0] exp);
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, redir, 1'b1, dreq, drdy, exp);
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [8:0] got;
        @(negedge clk);
        reset       = v.rst;
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_use_rs1  = v.use1;
        id_use_rs2  = v.use2;
        ex_rd       = v.exrd;
        ex_mem_read = v.exmr;
        ex_redirect = v.redir;
        imem_ready  = v.imrdy;
        dmem_req    = v.dreq;
        dmem_ready  = v.drdy;
        #2;
        got = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, exmem_flush, memwb_flush, bus_err};
        n_cmp++;
        if (got !== v.exp) begin
            n_fail++;
            $display("FAIL %s: outputs %b, required %b", name, got, v.exp);
        end
        if (v.rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (v.exp[8]) exp_stall++;
            if (v.exp[6] && v.exp[4]) exp_flush++;
        end
    endtask

    task automatic run_seq(input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("%s[%0d]", nm, i));
        end
        tbl.delete();
    endtask

    initial begin
        // reset, including a pending wait that must be masked
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_RST));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_RST));
        run_seq("reset");

        // single-cycle priority checks in RUN
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_NONE));
        tbl.push_back(mk(0, 5, 0, 1, 0, 5, 1, 0, 1, 0, 0, E_LU));
        tbl.push_back(mk(0, 5, 0, 1, 0, 5, 0, 0, 1, 0, 0, E_NONE));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, E_NONE));
        tbl.push_back(mk(0, 3, 7, 1, 1, 7, 1, 0, 1, 0, 0, E_LU));
        tbl.push_back(mk(0, 5, 0, 0, 0, 5, 1, 0, 1, 0, 0, E_NONE));
        tbl.push_back(mk(0, 9, 9, 1, 1, 9, 1, 0, 1, 0, 0, E_LU));
        tbl.push_back(mk(0, 5, 0, 1, 0, 5, 1, 1, 1, 0, 0, E_REDIR));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_FW));
        tbl.push_back(mk(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, E_LU));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_REDIR));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, E_NONE));
        run_seq("comb");

        // 3-cycle peripheral wait with a redirect frozen in EX; completes as counter would hit TIMEOUT
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 1, E_MEMW));
        tbl.push_back(w(1, 0, 1, E_MEMW));
        tbl.push_back(w(1, 1, 1, E_REDIR));
        tbl.push_back(w(0, 0, 0, E_NONE));
        tbl.push_back(w(0, 0, 0, E_NONE));
        run_seq("wait3");

        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 1, 0, E_NONE));
        tbl.push_back(w(0, 0, 0, E_NONE));
        run_seq("wait1");

        // timeout: 4 frozen cycles (load-use and fetch wait masked), abort, back to RUN
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(mk(0, 5, 0, 1, 0, 5, 1, 1, 0, 1, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_ABORT));
        tbl.push_back(w(0, 0, 0, E_NONE));
        tbl.push_back(w(0, 0, 0, E_NONE));
        run_seq("timeout");

        // reset in the 2nd MEM_WAIT cycle, then a full-length wait must still be needed to abort
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_RST));
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_ABORT));
        tbl.push_back(w(0, 0, 0, E_NONE));
        run_seq("rst_mid");

        // abort while a redirect sits in EX: front end flushes in the abort cycle
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 1, E_AB_RD));
        tbl.push_back(w(0, 0, 0, E_NONE));
        run_seq("abort_redir");

        // request withdrawn mid-wait, then a fresh wait still takes 4 cycles
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(0, 0, 0, E_NONE));
        tbl.push_back(w(0, 0, 0, E_NONE));
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_MEMW));
        tbl.push_back(w(1, 0, 0, E_ABORT));
        tbl.push_back(w(0, 0, 0, E_NONE));
        run_seq("drop");

        @(negedge clk);
        #2;
`ifdef HAZARD_CTRL_PERF_EN
        n_cmp++;
        if (perf_stall_cyc !== 32'(exp_stall)) begin
            n_fail++;
            $display("FAIL perf_stall_cyc: got %0d, required %0d", perf_stall_cyc, exp_stall);
        end
        n_cmp++;
        if (perf_flush_cnt !== 32'(exp_flush)) begin
            n_fail++;
            $display("FAIL perf_flush_cnt: got %0d, required %0d", perf_flush_cnt, exp_flush);
        end
`else
        n_cmp++;
        if (perf_stall_cyc !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_stall_cyc: got %0d, required 0", perf_stall_cyc);
        end
        n_cmp++;
        if (perf_flush_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_flush_cnt: got %0d, required 0", perf_flush_cnt);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
